// File: rtl/decoder_index_sequencer.sv
// Channel-index sequencer feeding the 2-to-4 decoder: walks the unmasked channels
// in ascending order, holding each for dwell+1 cycles, in auto-scan or single-sweep mode.
module decoder_index_sequencer #(
  parameter int DWELL_W = 8,
  parameter int IDX_W   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               mode,
  input  logic               start,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [3:0]         skip_mask,
  output logic [IDX_W-1:0]   sel,
  output logic               sel_valid,
  output logic               busy,
  output logic               wrap,
  output logic               done,
  output logic               err
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [IDX_W-1:0]   sel_q, sel_d;
  logic [DWELL_W-1:0] dwellCnt_q, dwellCnt_d;
  logic               selValid_q, selValid_d;
  logic               busy_q, busy_d;
  logic               wrap_q, wrap_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic [IDX_W-1:0]   firstIdx;
  logic [IDX_W-1:0]   nextIdx;
  logic [IDX_W-1:0]   cand;
  logic               nextWraps;
  logic               allMasked;
  logic               runReq;
  logic               autoAbort;

  // Priority searches: the smallest offset wins, so later loop passes override earlier ones.
  always_comb begin
    firstIdx = '0;
    for (int i = 3; i >= 0; i--) begin
      if (!skip_mask[i]) firstIdx = IDX_W'(i);
    end
    nextIdx = sel_q;
    cand    = sel_q;
    for (int k = 3; k >= 1; k--) begin
      cand = sel_q + IDX_W'(k);
      if (!skip_mask[cand]) nextIdx = cand;
    end
    nextWraps = (nextIdx <= sel_q);
  end

  assign allMasked = &skip_mask;
  assign runReq    = mode ? start : en;
  assign autoAbort = ~mode & ~en;

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    dwellCnt_d = dwellCnt_q;
    selValid_d = selValid_q;
    busy_d     = busy_q;
    wrap_d     = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (runReq) begin
          if (allMasked) begin
            err_d = 1'b1;
          end else begin
            state_d    = RUN;
            sel_d      = firstIdx;
            dwellCnt_d = dwell;
            selValid_d = 1'b1;
            busy_d     = 1'b1;
          end
        end
      end
      RUN: begin
        if (autoAbort) begin
          state_d    = IDLE;
          selValid_d = 1'b0;
          busy_d     = 1'b0;
        end else if (dwellCnt_q != '0) begin
          dwellCnt_d = dwellCnt_q - DWELL_W'(1);
        end else if (allMasked) begin
          state_d    = IDLE;
          selValid_d = 1'b0;
          busy_d     = 1'b0;
          err_d      = 1'b1;
        end else if (nextWraps && mode) begin
          // A single sweep ends instead of wrapping; sel keeps the last channel.
          state_d    = IDLE;
          selValid_d = 1'b0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
        end else begin
          sel_d      = nextIdx;
          dwellCnt_d = dwell;
          wrap_d     = nextWraps;
        end
      end
      default: begin
        state_d    = IDLE;
        selValid_d = 1'b0;
        busy_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      dwellCnt_q <= '0;
      selValid_q <= 1'b0;
      busy_q     <= 1'b0;
      wrap_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      dwellCnt_q <= dwellCnt_d;
      selValid_q <= selValid_d;
      busy_q     <= busy_d;
      wrap_q     <= wrap_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign sel       = sel_q;
  assign sel_valid = selValid_q;
  assign busy      = busy_q;
  assign wrap      = wrap_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: doc/decoder_index_sequencer.md
Name: decoder_index_sequencer

Overview:
Sequencer upstream of the 2-to-4 decoder. It produces the 2-bit channel index that the decoder turns into a one-hot line. It steps through channels 0..3 in ascending order with a programmable dwell time per channel, and channels can be skipped by mask. Two modes: continuous auto-scan, and single sweep started by a one-cycle start pulse.

Parameters:
DWELL_W, 8, width of dwell-time input and internal dwell counter
IDX_W, 2, width of channel index; fixed at 2 to match decoder input

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  auto-scan enable, level-sensitive (mode=0 only)
mode  input  1  0 = auto-scan, 1 = single sweep
start  input  1  one-cycle pulse, starts a sweep (mode=1 only)
dwell  input  DWELL_W  hold time per channel, in cycles minus 1
skip_mask  input  4  bit i = 1: channel i is skipped
sel  output  IDX_W  channel index to decoder
sel_valid  output  1  sel is active; decoder output is meaningful
busy  output  1  high while in RUN
wrap  output  1  one-cycle pulse when auto-scan wraps from last enabled channel to first
done  output  1  one-cycle pulse at end of a single sweep
err  output  1  one-cycle pulse when a run is requested with skip_mask = 4'b1111

Behaviour:
- One clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values, asserted immediately: sel=0, sel_valid=0, busy=0, wrap=0, done=0, err=0, dwell counter=0, state=IDLE.
- All outputs are registered.
- First enabled channel: lowest i with skip_mask[i]=0.
- Next enabled channel: nearest index above current with mask bit 0. Search wraps 3->0. Combinational priority search.
- State IDLE:
  - sel holds last value; sel_valid=0; busy=0.
  - Run request is (mode=0 & en) or (mode=1 & start).
  - Request with skip_mask=1111: stay IDLE, err=1 for one cycle.
  - Other request at edge k: sel=first enabled channel, counter=dwell, sel_valid=1, busy=1, go RUN. All take effect after edge k (latency 1).
  - start is ignored when mode=0; en is ignored when mode=1.
- State RUN:
  - Counter decrements each cycle. Each channel is held exactly dwell+1 cycles; dwell=0 gives 1 cycle per channel.
  - When counter==0 the next edge advances. sel=next enabled channel, counter reloaded from current dwell input.
  - dwell and skip_mask are sampled only at channel load. Mid-dwell changes take effect at the next advance.
  - Auto mode, advance wraps to a lower-or-equal index: wrap=1 for that cycle.
  - Auto mode, single enabled channel: sel stays constant; wrap pulses every dwell+1 cycles.
  - Single mode, advance would wrap: instead go IDLE, sel_valid=0, busy=0, done=1 for one cycle. sel retains last channel.
  - Auto mode with en=0 at an edge: go IDLE next cycle and abort the dwell. No wrap or done.
  - start while RUN in single mode: ignored; no restart.
  - Mode change while RUN: the remaining sweep completes under the new mode's rules from the next advance.
  - skip_mask becomes 1111 mid-run: at the next advance go IDLE and pulse err. No done or wrap.
- Reset mid-run: immediate return to reset values. No done, wrap, or err is produced.
- sel never drives a masked channel while sel_valid=1, provided skip_mask is stable at load.

Test Plan:
- Reset check: hold rst_n=0 mid-dwell with sel=2 -> outputs return to reset values asynchronously, before the next clk edge.
- Auto scan: mode=0, en=1, dwell=2, skip_mask=0000 -> sel sequence 0,0,0,1,1,1,2,2,2,3,3,3,0; wrap pulses on the cycle sel returns to 0; sel_valid stays 1.
- Skip mask: mode=0, dwell=0, skip_mask=0101 -> sel alternates 1,3,1,3; wrap on every return to 1.
- Single sweep: mode=1, dwell=1, skip_mask=1000, start pulse -> sel 0,0,1,1,2,2, then sel_valid=0 and done=1 one cycle; a second start during the sweep is ignored.
- All masked: skip_mask=1111, start pulse in mode=1 -> err=1 for one cycle; busy and sel_valid stay 0.
- Abort and dwell update: auto run with dwell=3; drop en mid-dwell -> IDLE next cycle, no wrap. Changing dwell from 3 to 0 mid-channel -> current channel still lasts 4 cycles; subsequent channels last 1 cycle.
